// File: rtl/vga_pkg.sv
// Shared types and default 640x480@60 timing constants for the VGA timing generator.
package vga_pkg;

   typedef enum logic [1:0] {
      PH_SYNC   = 2'd0,
      PH_BACK   = 2'd1,
      PH_ACTIVE = 2'd2,
      PH_FRONT  = 2'd3
   } phase_e;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_RUN  = 1'b1
   } run_e;

   localparam int DEF_H_ACTIVE = 640;
   localparam int DEF_H_FP     = 16;
   localparam int DEF_H_SYNC   = 96;
   localparam int DEF_H_BP     = 48;
   localparam int DEF_V_ACTIVE = 480;
   localparam int DEF_V_FP     = 10;
   localparam int DEF_V_SYNC   = 2;
   localparam int DEF_V_BP     = 33;

   function automatic int region_total(input int active, input int fp, input int sync, input int bp);
      return active + fp + sync + bp;
   endfunction

endpackage

// File: rtl/vga_axis_ctr.sv
// One timing axis: position counter plus SYNC/BACK/ACTIVE/FRONT phase FSM.
// Next-cycle values are exported so the parent can register outputs in step with the count.
module vga_axis_ctr
   import vga_pkg::*;
#(
   parameter int ACTIVE = DEF_H_ACTIVE,
   parameter int FP     = DEF_H_FP,
   parameter int SYNC   = DEF_H_SYNC,
   parameter int BP     = DEF_H_BP,
   parameter int CW     = 16
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          i_adv,
   output logic [CW-1:0] o_count,
   output logic [CW-1:0] o_count_next,
   output phase_e        o_phase_next,
   output logic          o_wrap
);
   localparam int TOTAL = region_total(ACTIVE, FP, SYNC, BP);
   localparam logic [CW-1:0] END_SYNC   = CW'(SYNC - 1);
   localparam logic [CW-1:0] END_BACK   = CW'(SYNC + BP - 1);
   localparam logic [CW-1:0] END_ACTIVE = CW'(SYNC + BP + ACTIVE - 1);
   localparam logic [CW-1:0] END_FRONT  = CW'(TOTAL - 1);

   if (ACTIVE < 1 || FP < 1 || SYNC < 1 || BP < 1 || (TOTAL >> CW) != 0) begin : g_bad_params
      $error("vga_axis_ctr: every region must be >= 1 and the total must fit in CW bits");
   end

   logic [CW-1:0] r_count, w_count_next;
   phase_e        r_phase, w_phase_next;
   logic          w_wrap;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_count <= '0;
         r_phase <= PH_SYNC;
      end else begin
         r_count <= w_count_next;
         r_phase <= w_phase_next;
      end
   end

   always_comb begin
      w_count_next = r_count;
      w_phase_next = r_phase;
      if (i_adv) begin
         w_count_next = w_wrap ? '0 : r_count + 1'b1;
         case (r_phase)
            PH_SYNC:   if (r_count == END_SYNC)   w_phase_next = PH_BACK;
            PH_BACK:   if (r_count == END_BACK)   w_phase_next = PH_ACTIVE;
            PH_ACTIVE: if (r_count == END_ACTIVE) w_phase_next = PH_FRONT;
            PH_FRONT:  if (w_wrap)                w_phase_next = PH_SYNC;
            default:                              w_phase_next = PH_SYNC;
         endcase
      end
   end

   always_comb begin
      w_wrap       = (r_count == END_FRONT);
      o_wrap       = w_wrap;
      o_count      = r_count;
      o_count_next = w_count_next;
      o_phase_next = w_phase_next;
   end

endmodule

// File: rtl/vga_timing_gen.sv
// VGA sync/blanking generator: pixel prescaler, idle/run control and two axis counters.
// Every output is registered from next-cycle values so nothing lags hCount/vCount.
module vga_timing_gen
   import vga_pkg::*;
#(
   parameter int   H_ACTIVE = DEF_H_ACTIVE,
   parameter int   H_FP     = DEF_H_FP,
   parameter int   H_SYNC   = DEF_H_SYNC,
   parameter int   H_BP     = DEF_H_BP,
   parameter int   V_ACTIVE = DEF_V_ACTIVE,
   parameter int   V_FP     = DEF_V_FP,
   parameter int   V_SYNC   = DEF_V_SYNC,
   parameter int   V_BP     = DEF_V_BP,
   parameter logic H_POL    = 1'b0,
   parameter logic V_POL    = 1'b0,
   parameter int   CLK_DIV  = 2,
   parameter int   CW       = 16
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          enable,
   output logic          hSync,
   output logic          vSync,
   output logic          bright,
   output logic [CW-1:0] hCount,
   output logic [CW-1:0] vCount,
   output logic [CW-1:0] pixelX,
   output logic [CW-1:0] pixelY,
   output logic          pixTick,
   output logic          lineStart,
   output logic          frameStart
);
   localparam int PW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam logic [PW-1:0] PRE_LAST = PW'(CLK_DIV - 1);
   localparam logic [CW-1:0] X_OFF    = CW'(H_SYNC + H_BP);
   localparam logic [CW-1:0] Y_OFF    = CW'(V_SYNC + V_BP);

   if (CLK_DIV < 1) begin : g_bad_div
      $error("vga_timing_gen: CLK_DIV must be at least 1");
   end

   run_e          r_state, w_state_next;
   logic [PW-1:0] r_presc, w_presc_next;
   logic          r_live, w_live_next;
   logic          w_tick, w_start, w_adv_h, w_adv_v, w_stop, w_bright_next;
   logic          w_hwrap, w_vwrap;
   logic [CW-1:0] w_hc_next, w_vc_next;
   phase_e        w_hph_next, w_vph_next;

   vga_axis_ctr #(.ACTIVE(H_ACTIVE), .FP(H_FP), .SYNC(H_SYNC), .BP(H_BP), .CW(CW)) u_h_axis (
      .clk(clk), .reset(reset), .i_adv(w_adv_h),
      .o_count(hCount), .o_count_next(w_hc_next), .o_phase_next(w_hph_next), .o_wrap(w_hwrap)
   );

   vga_axis_ctr #(.ACTIVE(V_ACTIVE), .FP(V_FP), .SYNC(V_SYNC), .BP(V_BP), .CW(CW)) u_v_axis (
      .clk(clk), .reset(reset), .i_adv(w_adv_v),
      .o_count(vCount), .o_count_next(w_vc_next), .o_phase_next(w_vph_next), .o_wrap(w_vwrap)
   );

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) r_state <= ST_IDLE;
      else        r_state <= w_state_next;
   end

   always_comb begin
      w_state_next = r_state;
      case (r_state)
         ST_IDLE: if (enable) w_state_next = ST_RUN;
         ST_RUN:  if (w_stop) w_state_next = ST_IDLE;
         default:             w_state_next = ST_IDLE;
      endcase
   end

   // The first tick after entering RUN starts the frame at (0,0) instead of advancing.
   always_comb begin
      w_tick        = (r_presc == PRE_LAST);
      w_start       = w_tick && (r_state == ST_RUN) && !r_live;
      w_adv_h       = w_tick && (r_state == ST_RUN) && r_live;
      w_adv_v       = w_adv_h && w_hwrap;
      w_stop        = w_adv_v && w_vwrap && !enable;
      w_presc_next  = (w_state_next == ST_RUN) ? (w_tick ? '0 : r_presc + 1'b1) : '0;
      w_live_next   = (w_state_next == ST_RUN) && (r_live || w_start);
      w_bright_next = w_live_next && (w_hph_next == PH_ACTIVE) && (w_vph_next == PH_ACTIVE);
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_presc    <= '0;
         r_live     <= 1'b0;
         hSync      <= ~H_POL;
         vSync      <= ~V_POL;
         bright     <= 1'b0;
         pixelX     <= '0;
         pixelY     <= '0;
         pixTick    <= 1'b0;
         lineStart  <= 1'b0;
         frameStart <= 1'b0;
      end else begin
         r_presc    <= w_presc_next;
         r_live     <= w_live_next;
         hSync      <= (w_live_next && w_hph_next == PH_SYNC) ? H_POL : ~H_POL;
         vSync      <= (w_live_next && w_vph_next == PH_SYNC) ? V_POL : ~V_POL;
         bright     <= w_bright_next;
         pixelX     <= w_bright_next ? w_hc_next - X_OFF : '0;
         pixelY     <= w_bright_next ? w_vc_next - Y_OFF : '0;
         pixTick    <= w_tick && (r_state == ST_RUN) && (w_state_next == ST_RUN);
         lineStart  <= w_start || (w_adv_h && w_hwrap && !w_stop);
         frameStart <= w_start || (w_adv_v && w_vwrap && !w_stop);
      end
   end

endmodule

// File: tb/tb_vga_timing_gen.sv
// Randomised enable/reset stimulus on three small timing configurations, each checked
// every cycle against a model that derives position from elapsed clocks since run start.
module tb_vga_timing_gen;
   localparam int CW = 16;
   localparam int C_DIV [3] = '{2, 1, 3};
   localparam int C_HA  [3] = '{8, 8, 4};
   localparam int C_HF  [3] = '{2, 1, 1};
   localparam int C_HS  [3] = '{3, 2, 1};
   localparam int C_HB  [3] = '{2, 1, 2};
   localparam int C_VA  [3] = '{5, 4, 3};
   localparam int C_VF  [3] = '{1, 1, 2};
   localparam int C_VS  [3] = '{2, 1, 1};
   localparam int C_VB  [3] = '{2, 1, 1};
   localparam bit C_HP  [3] = '{1'b0, 1'b1, 1'b1};
   localparam bit C_VP  [3] = '{1'b0, 1'b1, 1'b0};

   logic clk;
   logic rst_n;
   logic en;
   int   n_checks = 0;
   int   n_errors = 0;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_val(input string tag, input int obs, input int exp);
      n_checks++;
      if (obs != exp) begin
         n_errors++;
         $display("FAIL %s got %0d expected %0d at %0t", tag, obs, exp, $time);
      end
   endtask

   for (genvar gi = 0; gi < 3; gi++) begin : g_dut
      localparam int D  = C_DIV[gi];
      localparam int HA = C_HA[gi], HF = C_HF[gi], HS = C_HS[gi], HB = C_HB[gi];
      localparam int VA = C_VA[gi], VF = C_VF[gi], VS = C_VS[gi], VB = C_VB[gi];
      localparam bit HP = C_HP[gi], VP = C_VP[gi];
      localparam int HT = HA + HF + HS + HB;
      localparam int VT = VA + VF + VS + VB;
      localparam int FT = HT * VT;
      localparam int JS = (D > 1) ? D - 1 : 1;

      logic          hs, vs, br, pt, ls, fs;
      logic [CW-1:0] hc, vc, px, py;

      vga_timing_gen #(
         .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
         .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
         .H_POL(HP), .V_POL(VP), .CLK_DIV(D), .CW(CW)
      ) u_dut (
         .clk(clk), .reset(rst_n), .enable(en),
         .hSync(hs), .vSync(vs), .bright(br),
         .hCount(hc), .vCount(vc), .pixelX(px), .pixelY(py),
         .pixTick(pt), .lineStart(ls), .frameStart(fs)
      );

      // Model state: running flag and clock edges elapsed since the IDLE->RUN edge.
      bit m_run = 1'b0;
      int m_j   = 0;

      always @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            m_run = 1'b0;
         end else if (!m_run) begin
            if (en) begin
               m_run = 1'b1;
               m_j   = 0;
            end
         end else begin
            m_j = m_j + 1;
            if (m_j > JS && (m_j - JS) % D == 0 && ((m_j - JS) / D) % FT == 0 && !en)
               m_run = 1'b0;
         end
      end

      always @(negedge clk) begin
         int k, p, h, v;
         bit e_hs, e_vs, e_br, e_pt, e_ls, e_fs;
         int e_hc, e_vc, e_px, e_py;
         e_hc = 0; e_vc = 0; e_px = 0; e_py = 0;
         e_hs = !HP; e_vs = !VP; e_br = 1'b0; e_pt = 1'b0; e_ls = 1'b0; e_fs = 1'b0;
         if (m_run && m_j >= JS) begin
            k    = m_j - JS;
            p    = (k / D) % FT;
            h    = p % HT;
            v    = p / HT;
            e_hc = h;
            e_vc = v;
            e_hs = (h < HS) ? HP : !HP;
            e_vs = (v < VS) ? VP : !VP;
            e_br = (h >= HS + HB) && (h < HS + HB + HA) && (v >= VS + VB) && (v < VS + VB + VA);
            e_px = e_br ? h - (HS + HB) : 0;
            e_py = e_br ? v - (VS + VB) : 0;
            e_pt = (k % D == 0);
            e_ls = e_pt && (h == 0);
            e_fs = e_pt && (p == 0);
         end
         check_val($sformatf("u%0d.hCount", gi),     int'(hc), e_hc);
         check_val($sformatf("u%0d.vCount", gi),     int'(vc), e_vc);
         check_val($sformatf("u%0d.pixelX", gi),     int'(px), e_px);
         check_val($sformatf("u%0d.pixelY", gi),     int'(py), e_py);
         check_val($sformatf("u%0d.hSync", gi),      int'(hs), int'(e_hs));
         check_val($sformatf("u%0d.vSync", gi),      int'(vs), int'(e_vs));
         check_val($sformatf("u%0d.bright", gi),     int'(br), int'(e_br));
         check_val($sformatf("u%0d.pixTick", gi),    int'(pt), int'(e_pt));
         check_val($sformatf("u%0d.lineStart", gi),  int'(ls), int'(e_ls));
         check_val($sformatf("u%0d.frameStart", gi), int'(fs), int'(e_fs));
      end
   end

   initial begin
      int r;
      rst_n = 1'b1;
      en    = 1'b0;
      #1 rst_n = 1'b0;
      repeat (3) @(posedge clk);
      #2 rst_n = 1'b1;
      // Several full frames, then a drop so every configuration finishes a frame and idles.
      en = 1'b1;
      repeat (700) @(posedge clk);
      #2 en = 1'b0;
      repeat (400) @(posedge clk);
      for (int it = 0; it < 80; it++) begin
         r = int'($urandom_range(0, 9));
         @(posedge clk);
         #2;
         if (r < 2) begin
            rst_n = 1'b0;
            en    = 1'($urandom_range(0, 1));
            repeat ($urandom_range(1, 3)) @(posedge clk);
            #2 rst_n = 1'b1;
         end else begin
            en = (r < 7);
         end
         repeat ($urandom_range(20, 600)) @(posedge clk);
      end
      @(posedge clk);
      #7;
      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/vga_timing_gen.md
VGA_TIMING_GEN -- requirements
Module: vga_timing_gen

Interface
REQ-001 SHALL have parameter H_ACTIVE, default 640, meaning visible pixels per line.
REQ-002 SHALL have parameter H_FP, default 16, meaning horizontal front-porch pixels.
REQ-003 SHALL have parameter H_SYNC, default 96, meaning horizontal sync pixels.
REQ-004 SHALL have parameter H_BP, default 48, meaning horizontal back-porch pixels.
REQ-005 SHALL have parameters V_ACTIVE/V_FP/V_SYNC/V_BP, defaults 480/10/2/33, meaning the same quantities in lines.
REQ-006 SHALL have parameter H_POL/V_POL, default 0/0, meaning sync level while asserted (0 = active-low).
REQ-007 SHALL have parameter CLK_DIV, default 2, meaning clk cycles per pixel (>=1).
REQ-008 SHALL have parameter CW, default 16, meaning counter and coordinate width.
REQ-009 Port: clk, input, 1, system clock.
REQ-010 Port: reset, input, 1, asynchronous, active-low reset.
REQ-011 Port: enable, input, 1, run request; sampled only at frame boundary.
REQ-012 Port: hSync, vSync, output, 1 each, sync pulses with polarity per H_POL/V_POL.
REQ-013 Port: bright, output, 1, high in the active region only.
REQ-014 Port: hCount, vCount, output, CW each, raw position within line/frame.
REQ-015 Port: pixelX, pixelY, output, CW each, active-area coordinate; 0 when bright=0.
REQ-016 Port: pixTick, output, 1, one-clk pulse each pixel advance.
REQ-017 Port: lineStart, frameStart, output, 1 each, one-clk pulses.

Function
REQ-018 Line order SHALL be SYNC, BACK, ACTIVE, FRONT from hCount=0; H_TOTAL = sum of the four H parameters (default 800). Vertical order and V_TOTAL (525) are defined the same way.
REQ-019 A prescaler SHALL count 0..CLK_DIV-1 and assert pixTick when it wraps. With CLK_DIV=1, pixTick SHALL be held high.
REQ-020 hCount SHALL advance only on pixTick. At H_TOTAL-1 it SHALL wrap to 0, and vCount SHALL advance on that same tick.
REQ-021 vCount SHALL wrap from V_TOTAL-1 to 0 on the tick where hCount also wraps.
REQ-022 Each axis SHALL hold a phase FSM (SYNC, BACK, ACTIVE, FRONT). Phase transitions SHALL occur on the tick where the count crosses a region boundary, and the phase SHALL always match the count.
REQ-023 All outputs SHALL be registered and consistent with hCount/vCount in the same cycle; no output may lag the counters by a cycle.
REQ-024 In the SYNC phase, hSync SHALL equal H_POL; otherwise it SHALL equal ~H_POL. vSync SHALL behave the same way with V_POL.
REQ-025 bright SHALL equal (hPhase==ACTIVE && vPhase==ACTIVE).
REQ-026 pixelX SHALL be hCount-(H_SYNC+H_BP) and pixelY SHALL be vCount-(V_SYNC+V_BP) while bright=1; otherwise both SHALL be 0.
REQ-027 lineStart SHALL pulse on the tick where hCount becomes 0. frameStart SHALL pulse when both counters become 0.
REQ-028 An idle/run FSM SHALL control operation. In IDLE, counters stay at 0, syncs are deasserted, and bright=0. Once enable=1, the FSM SHALL go to RUN on the next clk.
REQ-029 enable=0 during RUN SHALL take effect only at frame end: the current frame completes, then the FSM enters IDLE without a frameStart pulse.
REQ-030 Arithmetic SHALL be CW bits wide. Parameter totals of 2**CW or more SHALL be rejected at elaboration.

Reset
REQ-031 When reset=0, all state SHALL clear immediately and asynchronously: FSM=IDLE, prescaler=0, hCount=vCount=0, pixelX=pixelY=0, bright=0, all pulses=0, hSync=~H_POL, vSync=~V_POL.
REQ-032 Reset asserted mid-frame SHALL abort the frame. After release, the block SHALL restart only through the IDLE/enable path.

Structure
REQ-033 Phase enum, idle/run enum and default 640x480 timing constants SHALL live in package vga_pkg.
REQ-034 One axis sub-module, vga_axis_ctr, SHALL be instantiated twice. It contains a counter, phase FSM and wrap output, with the four region lengths as parameters.

Verification
REQ-035 Defaults, enable=1: lineStart SHALL occur every 1600 clk and frameStart every 840000 clk; hSync SHALL be low for 192 clk per line.
REQ-036 Defaults: the first bright=1 SHALL occur at hCount=144, vCount=35 with pixelX=0, pixelY=0; the last SHALL occur at hCount=783, vCount=514 with pixelX=639, pixelY=479.
REQ-037 H_POL=1, V_POL=1: hSync SHALL be high for hCount 0..95 and vSync high for vCount 0..1, and both low otherwise.
REQ-038 enable dropped at vCount=200: the frame SHALL run to vCount=524, hCount=799. The FSM SHALL then go IDLE with counters at 0 and no frameStart pulse.
REQ-039 Reset asserted at hCount=400, vCount=300: outputs SHALL equal reset values in the same cycle. With enable held at 1, frameStart SHALL follow 2 clk after release.
REQ-040 CLK_DIV=1, H=8/1/2/1, V=4/1/1/1: H_TOTAL=12 and V_TOTAL=7; the frame period SHALL be 84 clk and the wraps SHALL be exact.
